// File: rtl/snes_rom_pkg.sv
// Shared definitions for the SNES cartridge ROM port.
//   ROM_ADDR_W : default ROM byte-address width
//   ROM_CNT_W  : default width of the saturating fetch counter
//   rom_state_e: request FSM states
//   rom_fmt    : byte/word return formatting toward the mappers
package snes_rom_pkg;

  localparam int unsigned ROM_ADDR_W = 24;
  localparam int unsigned ROM_CNT_W  = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } rom_state_e;

  // Word reads return the whole line. Byte reads replicate the addressed
  // byte on both lanes, so mappers may take either half of the bus.
  function automatic logic [15:0] rom_fmt(input logic [15:0] line,
                                          input logic        a0,
                                          input logic        word);
    logic [7:0] b;
    b = a0 ? line[15:8] : line[7:0];
    return word ? line : {b, b};
  endfunction

endpackage

// File: rtl/snes_rom_line.sv
// Single-entry ROM line cache: one tag, one 16-bit data word, one valid bit.
//   clk, rst   : clock and synchronous active-high reset
//   inv        : clears the valid bit (takes priority over fill)
//   fill       : loads fill_tag/fill_data and marks the line valid
//   lookup_wa  : word address being looked up
//   hit        : line valid and tag matches lookup_wa
//   line       : cached data word
module snes_rom_line #(
  parameter int unsigned WA_W = 23
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inv,
  input  logic            fill,
  input  logic [WA_W-1:0] fill_tag,
  input  logic [15:0]     fill_data,
  input  logic [WA_W-1:0] lookup_wa,
  output logic            hit,
  output logic [15:0]     line
);

  logic            valid_r;
  logic [WA_W-1:0] tag_r;
  logic [15:0]     data_r;

  assign hit  = valid_r & (tag_r == lookup_wa);
  assign line = data_r;

  // Line storage: reset clears everything, invalidation beats a fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      tag_r   <= {WA_W{1'b0}};
      data_r  <= 16'h0000;
    end else if (inv) begin
      valid_r <= 1'b0;
    end else if (fill) begin
      valid_r <= 1'b1;
      tag_r   <= fill_tag;
      data_r  <= fill_data;
    end
  end

endmodule

// File: rtl/snes_rom_port.sv
// ROM read port between the mapper mux and the SDRAM controller.
// Turns the mapper's level-style read into a req/ack memory transaction,
// keeps a one-word line cache and formats byte/word returns.
//   mclk, rst            : clock and synchronous active-high reset
//   rom_addr/mask        : mapper byte address and ROM size mask
//   rom_ce_n/oe_n        : active-low strobes; both low = active access
//   rom_word             : 1 = 16-bit read, 0 = byte read
//   cache_inv            : pulse that invalidates the line (ROM reload)
//   rom_q                : registered read data to the mappers
//   rom_busy             : active access not yet satisfied by the cache
//   mem_req/addr/ack/rdata : memory handshake (level req, pulse ack)
//   fetch_cnt            : saturating count of accepted fetches
module snes_rom_port
  import snes_rom_pkg::*;
#(
  parameter int unsigned ADDR_W = ROM_ADDR_W,
  parameter int unsigned CNT_W  = ROM_CNT_W
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ce_n,
  input  logic              rom_oe_n,
  input  logic              rom_word,
  input  logic [ADDR_W-1:0] rom_mask,
  input  logic              cache_inv,
  output logic [15:0]       rom_q,
  output logic              rom_busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [CNT_W-1:0]  fetch_cnt
);

  logic              active_s;
  logic [ADDR_W-1:0] ea_s;
  logic [ADDR_W-2:0] wa_s;
  logic              hit_s;
  logic [15:0]       line_s;

  rom_state_e        state_r;
  rom_state_e        state_nxt_s;
  logic              issue_s;
  logic              ack_s;
  logic              fill_s;
  logic              bypass_s;

  logic [ADDR_W-2:0] req_wa_r;
  logic              discard_r;
  logic [15:0]       rom_q_r;
  logic              mem_req_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [CNT_W-1:0]  fetch_cnt_r;

  assign active_s  = ~rom_ce_n & ~rom_oe_n;
  assign ea_s      = rom_addr & rom_mask;
  assign wa_s      = ea_s[ADDR_W-1:1];
  assign rom_busy  = active_s & ~hit_s;

  assign rom_q     = rom_q_r;
  assign mem_req   = mem_req_r;
  assign mem_addr  = mem_addr_r;
  assign fetch_cnt = fetch_cnt_r;

  snes_rom_line #(
    .WA_W (ADDR_W - 1)
  ) u_line (
    .clk       (mclk),
    .rst       (rst),
    .inv       (cache_inv),
    .fill      (fill_s),
    .fill_tag  (req_wa_r),
    .fill_data (mem_rdata),
    .lookup_wa (wa_s),
    .hit       (hit_s),
    .line      (line_s)
  );

  // FSM state register.
  always_ff @(posedge mclk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: a miss opens a request, the ack closes it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (active_s && !hit_s) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = REQ;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs. An invalidate arriving with the ack discards that ack just
  // like one that arrived earlier in REQ; acks seen in IDLE are ignored.
  always_comb begin
    issue_s  = 1'b0;
    ack_s    = 1'b0;
    fill_s   = 1'b0;
    bypass_s = 1'b0;
    case (state_r)
      IDLE: begin
        issue_s = active_s & ~hit_s;
      end
      REQ: begin
        ack_s    = mem_ack;
        fill_s   = mem_ack & ~discard_r & ~cache_inv;
        bypass_s = fill_s & active_s & (req_wa_r == wa_s);
      end
      default: begin
        issue_s = 1'b0;
      end
    endcase
  end

  // Request registers: address latched at issue and frozen until the ack.
  always_ff @(posedge mclk) begin
    if (rst) begin
      mem_req_r  <= 1'b0;
      mem_addr_r <= {ADDR_W{1'b0}};
      req_wa_r   <= {(ADDR_W - 1){1'b0}};
    end else if (issue_s) begin
      mem_req_r  <= 1'b1;
      mem_addr_r <= {wa_s, 1'b0};
      req_wa_r   <= wa_s;
    end else if (ack_s) begin
      mem_req_r  <= 1'b0;
    end
  end

  // Discard flag: set by an invalidate while a request is outstanding.
  always_ff @(posedge mclk) begin
    if (rst) begin
      discard_r <= 1'b0;
    end else if (state_r == REQ) begin
      if (ack_s) begin
        discard_r <= 1'b0;
      end else if (cache_inv) begin
        discard_r <= 1'b1;
      end
    end else begin
      discard_r <= 1'b0;
    end
  end

  // Read data: bypass the fresh ack data, otherwise serve cache hits.
  always_ff @(posedge mclk) begin
    if (rst) begin
      rom_q_r <= 16'h0000;
    end else if (bypass_s) begin
      rom_q_r <= rom_fmt(mem_rdata, ea_s[0], rom_word);
    end else if (active_s && hit_s) begin
      rom_q_r <= rom_fmt(line_s, ea_s[0], rom_word);
    end
  end

  // Saturating count of fetches that actually filled the line.
  always_ff @(posedge mclk) begin
    if (rst) begin
      fetch_cnt_r <= {CNT_W{1'b0}};
    end else if (fill_s && (fetch_cnt_r != {CNT_W{1'b1}})) begin
      fetch_cnt_r <= fetch_cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: doc/snes_rom_port.md
Name: snes_rom_port

Overview:
- Sits directly downstream of the cartridge mapper mux. Consumes the selected mapper's ROM_ADDR / ROM_CE_N / ROM_OE_N / ROM_WORD and produces ROM_Q.
- Converts the mapper's level-style ROM read into a req/ack transaction toward the SDRAM controller.
- Keeps a single-entry 16-bit line cache, so repeated reads of the same word cost no memory transaction.
- Formats byte vs word returns and exposes a busy flag and a fetch counter for debug.

Parameters:
ADDR_W, 24, ROM byte-address width
CNT_W, 16, width of saturating fetch counter

Ports:
mclk  in  1  system master clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
rom_addr  in  ADDR_W  byte address from mapper mux
rom_ce_n  in  1  ROM chip enable, active low
rom_oe_n  in  1  ROM output enable, active low
rom_word  in  1  1 = 16-bit read, 0 = byte read
rom_mask  in  ADDR_W  ROM size mask
cache_inv  in  1  one-cycle pulse; invalidates the cache line (ROM reload)
rom_q  out  16  read data to mappers (registered)
rom_busy  out  1  active access whose data is not yet in the cache
mem_req  out  1  memory request, level, held until ack
mem_addr  out  ADDR_W  word-aligned request address, bit 0 = 0
mem_ack  in  1  one-cycle pulse; mem_rdata valid in the same cycle
mem_rdata  in  16  little-endian word: [7:0] = even byte
fetch_cnt  out  CNT_W  accepted fetches, saturating

Behaviour:
- Reset is synchronous, active-high, single clock mclk. When rst=1 at an edge: rom_q=0, mem_req=0, mem_addr=0, cache valid=0, fetch_cnt=0, state=IDLE, discard flag=0.
- Definitions:
  - active = !rom_ce_n & !rom_oe_n
  - ea = rom_addr & rom_mask
  - wa = ea[ADDR_W-1:1]
  - hit = valid & (tag == wa)
- Output formatting, f(line, ea, word):
  - word=1: line; ea[0] is ignored.
  - word=0: {b, b}, where b = ea[0] ? line[15:8] : line[7:0].
- rom_q:
  - Every cycle with active & hit: rom_q <= f(line, ea, rom_word).
  - Otherwise rom_q holds its value.
  - Latency from a hit access to rom_q valid is 1 cycle.
- rom_busy = active & !hit (combinational from registered tag/valid).
- FSM states: IDLE, REQ.
  - IDLE, active & !hit: go to REQ; set mem_req=1 and mem_addr={wa,1'b0} at the same edge; latch req_wa=wa.
  - IDLE, otherwise: stay; mem_req=0.
  - REQ: mem_req and mem_addr are held stable until mem_ack. Changes on rom_addr during REQ do not alter the outstanding request.
  - REQ, mem_ack=1: mem_req<=0; go to IDLE.
    - If discard=0: line<=mem_rdata, tag<=req_wa, valid<=1, fetch_cnt++ (saturating at all-ones).
    - If req_wa equals the current wa and active: rom_q <= f(mem_rdata, ea, rom_word) at the same edge (bypass).
  - After returning to IDLE, a changed address is re-evaluated next cycle. Miss-to-data latency = 1 + controller latency + 0 (bypass).
- cache_inv:
  - Clears valid at that edge.
  - If it arrives in REQ, or in the same cycle as mem_ack, set discard=1. That ack's data is not cached, does not bypass, and does not count. Discard clears on leaving REQ.
  - cache_inv in IDLE with active & hit: the next cycle is a miss.
- A mem_ack received in IDLE is ignored; this covers a late ack after reset.
- Reset during REQ: mem_req drops at that edge. The controller must tolerate an abandoned request.
- Inactive (ce_n or oe_n high): no new requests. An outstanding REQ still completes and fills the cache.
- Wrap-around: wa at all-ones is handled normally. The masked address never exceeds rom_mask.

Decomposition:
- Package snes_rom_pkg:
  - constants ROM_ADDR_W=24, ROM_CNT_W=16
  - state enum {IDLE, REQ}
  - function rom_fmt(line, a0, word) implementing f
- Sub-module snes_rom_line: single-entry tag/data/valid register with inv and fill ports, plus the hit compare. The FSM and counter stay in snes_rom_port.

Test Plan:
- Cold read, rom_mask=FFFFFF, addr=012345, word=0:
  - mem_req rises 1 cycle after the access, with mem_addr=012344.
  - Ack with rdata=BEEF: rom_q=BEBE the cycle after the ack; fetch_cnt=1.
- Same access, addr=012344, word=1 → no mem_req; rom_q=BEEF after 1 cycle; rom_busy=0.
- Address changes to 020000 while REQ for 012344 is pending:
  - mem_addr stays 012344 until ack; no bypass to rom_q.
  - Then a second req for 020000; fetch_cnt=2.
- cache_inv pulsed during REQ:
  - Ack data is discarded (fetch_cnt unchanged).
  - A new req for the same word is issued next cycle.
- rst asserted while mem_req=1:
  - All outputs are 0 next cycle.
  - A subsequent stray mem_ack has no effect on rom_q or fetch_cnt.
- rom_mask=0FFFFF, addr=312346 → mem_addr=012346; fetch_cnt saturates at FFFF after forced 65536+ misses.
